recon_frame_reader: RTL and testbench
=====================================

# recon_frame_reader

Readout stage directly downstream of the spike-window reconstruction memory. On each `save_done` pulse it walks the saved window-size memory (5000 lines × 50 pixels × 8 bit) through the memory's read port (`addr_q`/`ce0`/`q0`). It converts each window size to an 8-bit intensity and streams the frame out as a valid/ready beat stream of 10 pixels per beat, with start-of-frame and end-of-frame markers. A credit-based two-line buffer absorbs the memory read latency and downstream backpressure without losing data.

## Interface
- `LINES`, 5000, lines per frame; addresses 0..LINES-1
- `PIX_PER_LINE`, 50, 8-bit pixels per memory word (`q0` width = 8·PIX_PER_LINE = 400)
- `PIX_PER_BEAT`, 10, pixels per output beat; must divide PIX_PER_LINE (5 beats/line)
- `RD_LAT`, 2, cycles from `ce0` high to `q0` valid; fixed, no read-valid returned
- `clk_200M` in 1: the single clock
- `rst_200M` in 1: synchronous, active-high reset
- `save_done` in 1: one-cycle pulse; memory frame complete, start readout
- `addr_q` out 13: memory read address
- `ce0` out 1: memory read enable, one cycle per line
- `q0` in 400: read data; pixel p = `q0[8p+:8]`
- `m_data` out 80: pixel k of beat = `m_data[8k+:8]`
- `m_valid` out 1: beat valid
- `m_ready` in 1: downstream accept; transfer when `m_valid & m_ready`
- `m_user` out 1: first beat of frame (line 0, beat 0)
- `m_last` out 1: last beat of frame (line LINES-1, beat 4)
- `busy` out 1: readout in progress
- `overrun` out 1: sticky; `save_done` arrived while busy

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: `busy`=0. `save_done` → READ, read address counter `ra`=0.
- READ: issue a read (`ce0`=1, `addr_q`=`ra`, `ra`++) in any cycle where occupied buffer lines + in-flight reads < 2. After issuing `ra`=LINES-1 → DRAIN.
- DRAIN: no reads issued. When the last beat of line LINES-1 transfers → IDLE.
- Capture: a shift register of depth RD_LAT tracks in-flight reads. `q0` is written into the 2-entry line buffer exactly RD_LAT cycles after its `ce0`. Buffer pointers wrap mod 2.
- Output: the head line is sliced into beats 0..4 with a beat counter. The counter advances on transfer. After beat 4 transfers, the line slot frees and the head pointer advances.
- Output line counter 0..LINES-1 drives `m_user`/`m_last`.
- Pixel map, per 8-bit val v: out = 0 if v==255 (no spike in window); otherwise out = 255−v. Pure function; there is no arithmetic overflow.
- `m_data`/`m_user`/`m_last` stay stable while `m_valid & !m_ready` (AXI-stream rule).
- `save_done` while `busy`: ignored, `overrun`←1. `overrun` is cleared only by reset.
- `save_done` in the same cycle as the DRAIN→IDLE transition: treated as busy (overrun).

## Timing
- Reset: all outputs 0 (`addr_q`=0, `ce0`=0, `m_data`=0, `m_valid`=0, `m_user`=0, `m_last`=0, `busy`=0, `overrun`=0). State IDLE; buffer, pointers and in-flight tracker cleared.
- Reset mid-frame: the readout is abandoned. Any `q0` arriving afterwards is discarded. The next `save_done` starts cleanly at line 0.
- `save_done` at cycle 0: `busy`=1 and `ce0`=1 with `addr_q`=0 at cycle 1. Line 0 is captured at the end of cycle 1+RD_LAT. `m_valid`=1 and `m_user`=1 at cycle 2+RD_LAT (cycle 4 at default).
- With `m_ready` held high: one beat per cycle, no bubbles after the first beat. One read per 5 cycles at steady state. Frame = 25000 beats.
- `busy` drops the cycle after the `m_last` transfer.
- `ce0` is never high in IDLE or DRAIN. Exactly LINES reads per frame.

## Test plan
- Memory model with RD_LAT=2 holding val = (line+p) mod 256. `save_done`, `m_ready`=1 → first beat at cycle 4 with `m_user`=1. Pixel 0 = 255. Pixel 1 (val 1) = 254. Exactly 25000 beats, `m_last` only on beat 24999, 5000 `ce0` pulses with addresses 0..4999 in order.
- Pixel map corners: val 0→255, 1→254, 254→1, 255→0 across all 50 lanes.
- Random `m_ready` (30% high) → stream identical to the first scenario. Data held stable while stalled. Never more than 2 lines buffered plus in flight. No read issued when the buffer is full.
- `m_ready`=0 for 100 cycles from start → exactly 2 `ce0` pulses (lines 0,1), then none until beats drain.
- Second `save_done` at beat 1000 → `overrun`=1, frame still ends at beat 24999. `save_done` after `busy`=0 starts a new frame at line 0.
- `rst_200M` at beat 12345 → all outputs 0 next cycle. Late `q0` ignored. The following `save_done` yields a full, correct 25000-beat frame.

Source files
------------

// File: rtl/recon_frame_reader.sv
// ---------------------------------------------------------------------------
// recon_frame_reader
//
// Reads one saved frame of window sizes out of the reconstruction memory and
// streams it downstream as intensity pixels, PIX_PER_BEAT pixels per beat.
//
// A two-slot line buffer sits between the memory read port and the output.
// Reads are only issued while (buffered lines + reads in flight) < 2, so a
// line returning from memory always has a free slot to land in. This lets the
// block absorb the fixed memory latency and arbitrary downstream stalls.
//
// Ports
//   clk_200M   : clock
//   rst_200M   : synchronous active-high reset
//   save_done  : one-cycle pulse, a complete frame is in memory
//   addr_q     : memory read address (line number)
//   ce0        : memory read enable, one cycle per line
//   q0         : memory read data, valid RD_LAT cycles after ce0
//   m_data     : output beat, pixel k in m_data[8k+:8]
//   m_valid    : output beat valid
//   m_ready    : downstream accept
//   m_user     : first beat of the frame
//   m_last     : last beat of the frame
//   busy       : a readout is in progress
//   overrun    : sticky, save_done arrived while busy
// ---------------------------------------------------------------------------
module recon_frame_reader #(
    parameter int LINES        = 5000,
    parameter int PIX_PER_LINE = 50,
    parameter int PIX_PER_BEAT = 10,
    parameter int RD_LAT       = 2,
    localparam int AW          = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic                      clk_200M,
    input  logic                      rst_200M,
    input  logic                      save_done,
    output logic [AW-1:0]             addr_q,
    output logic                      ce0,
    input  logic [8*PIX_PER_LINE-1:0] q0,
    output logic [8*PIX_PER_BEAT-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_user,
    output logic                      m_last,
    output logic                      busy,
    output logic                      overrun
);

    localparam int BPL = PIX_PER_LINE / PIX_PER_BEAT;
    localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int LW  = 8 * PIX_PER_LINE;
    localparam int DW  = 8 * PIX_PER_BEAT;

    localparam logic [AW-1:0] LAST_LINE = AW'(LINES - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BPL - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    genvar gi;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     ra_q, ra_d;          // next line to request
    logic [RD_LAT-1:0] pipe_q, pipe_d;      // reads in the memory pipeline
    logic [LW-1:0]     lbuf_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;               // lines held in lbuf_q
    logic [BW-1:0]     beat_q;              // beat within the head line
    logic [AW-1:0]     oline_q;             // line currently being output
    logic              overrun_q;

    logic              xfer;
    logic              line_done;
    logic              frame_done;
    logic              capture;
    logic              start;
    logic              issue;
    logic [AW-1:0]     issue_addr;
    logic [7:0]        used;

    // Credit accounting: a read is "used" from the cycle ce0 is high
    // until its line has been fully sent.
    always_comb begin
        used = 8'(occ_q) + 8'(ce0);
        for (int i = 0; i < RD_LAT; i++) begin
            used = used + 8'(pipe_q[i]);
        end
    end

    // ce0 is a register, so the read presented in a cycle was decided in
    // the previous one; the pipeline stages therefore start from ce0 and
    // the last stage marks the cycle in which q0 carries that line.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = ce0;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign capture    = pipe_q[RD_LAT-1];
    assign m_valid    = (occ_q != 2'd0);
    assign xfer       = m_valid & m_ready;
    assign line_done  = xfer && (beat_q == LAST_BEAT);
    assign frame_done = line_done && (oline_q == LAST_LINE);
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

    // The first read goes out together with the IDLE->READ transition so
    // that line 0 is on the address bus the cycle after save_done.
    assign start      = (state_q == S_IDLE) && save_done;
    assign issue      = start || ((state_q == S_READ) && (used < 8'd2));
    assign issue_addr = start ? '0 : ra_q;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        if (issue) begin
            if (issue_addr == LAST_LINE) begin
                state_d = S_DRAIN;
                ra_d    = '0;
            end else begin
                state_d = S_READ;
                ra_d    = issue_addr + AW'(1);
            end
        end else if ((state_q == S_DRAIN) && frame_done) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_200M) begin
        if (rst_200M) begin
            state_q   <= S_IDLE;
            ra_q      <= '0;
            addr_q    <= '0;
            ce0       <= 1'b0;
            pipe_q    <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            beat_q    <= '0;
            oline_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            ce0     <= issue;
            if (issue) begin
                addr_q <= issue_addr;
            end
            pipe_q <= pipe_d;
            if (capture) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (line_done) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + 2'(capture) - 2'(line_done);
            if (xfer) begin
                beat_q <= line_done ? '0 : beat_q + BW'(1);
            end
            if (line_done) begin
                oline_q <= frame_done ? '0 : oline_q + AW'(1);
            end
            // busy already covers the cycle of the final DRAIN->IDLE step.
            if (save_done && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Line buffer; a slot is only rewritten after its line has been sent,
    // which keeps the presented beat stable during a stall.
    always_ff @(posedge clk_200M) begin
        if (rst_200M) begin
            lbuf_q[0] <= '0;
            lbuf_q[1] <= '0;
        end else if (capture) begin
            lbuf_q[wr_ptr_q] <= q0;
        end
    end

    // ------------------------------------------------------------------
    // Output slicing and pixel map
    // ------------------------------------------------------------------
    logic [LW-1:0] head_line;
    logic [DW-1:0] beat_words [BPL];
    logic [DW-1:0] beat_sel;

    assign head_line = lbuf_q[rd_ptr_q];

    generate
        for (gi = 0; gi < BPL; gi++) begin : g_slice
            assign beat_words[gi] = head_line[gi*DW +: DW];
        end
    endgenerate

    assign beat_sel = beat_words[beat_q];

    // Window size 255 means no spike in the window: black. Otherwise a
    // shorter window is a brighter pixel.
    generate
        for (gi = 0; gi < PIX_PER_BEAT; gi++) begin : g_pix
            logic [7:0] v;
            assign v = beat_sel[gi*8 +: 8];
            assign m_data[gi*8 +: 8] = !m_valid      ? 8'd0 :
                                       (v == 8'hFF)  ? 8'd0 :
                                                       (8'hFF - v);
        end
    endgenerate

    assign m_user = m_valid && (beat_q == '0) && (oline_q == '0);
    assign m_last = m_valid && (beat_q == LAST_BEAT) && (oline_q == LAST_LINE);

endmodule

// File: tb/tb_recon_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_recon_frame_reader
//
// Drives recon_frame_reader against a latency-2 memory model and checks the
// output stream beat by beat against an arithmetic model of the frame:
// beat n carries line n/5, pixels (n%5)*10 .. +9, each mapped 255-v with
// 255 -> 0. Reads are tracked from the outside to confirm ordering and the
// two-line credit limit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_recon_frame_reader;

    localparam int LINES = 5000;
    localparam int BPL   = 5;
    localparam int TOTAL = LINES * BPL;

    logic         clk = 1'b0;
    logic         rst_200M;
    logic         save_done;
    logic [12:0]  addr_q;
    logic         ce0;
    logic [399:0] q0;
    logic [79:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_user;
    logic         m_last;
    logic         busy;
    logic         overrun;

    always #5 clk = ~clk;

    recon_frame_reader dut (
        .clk_200M  (clk),
        .rst_200M  (rst_200M),
        .save_done (save_done),
        .addr_q    (addr_q),
        .ce0       (ce0),
        .q0        (q0),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_user    (m_user),
        .m_last    (m_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Memory contents: mode 0 -> (line+p) mod 256, mode 1 -> per-line corner value
    int          mem_mode = 0;
    logic [31:0] corner_word = '0;

    function automatic logic [7:0] mem_val(input int mode, input int line, input int p,
                                           input logic [31:0] cw);
        if (mode == 0) return 8'((line + p) % 256);
        return cw[8*(line % 4) +: 8];
    endfunction

    function automatic logic [7:0] pix_map(input logic [7:0] v);
        if (v == 8'd255) return 8'd0;
        return 8'(255 - int'(v));
    endfunction

    // Memory with two cycles from ce0 to q0; not affected by the DUT reset.
    logic [12:0] a1, a2;
    logic        v1, v2;
    always @(posedge clk) begin
        a1 <= addr_q;
        v1 <= ce0;
        a2 <= a1;
        v2 <= v1;
    end
    always_comb begin
        q0 = '0;
        for (int p = 0; p < 50; p++) begin
            q0[8*p +: 8] = v2 ? mem_val(mem_mode, int'(a2), p, corner_word) : 8'hA5;
        end
    end

    // Expected {user, last, data} of beat n
    function automatic logic [81:0] exp_beat(input int n);
        logic [79:0] d;
        int line, b;
        line = n / BPL;
        b    = n % BPL;
        for (int k = 0; k < 10; k++) begin
            d[8*k +: 8] = pix_map(mem_val(mem_mode, line, b*10 + k, corner_word));
        end
        return {(n == 0), (n == TOTAL - 1), d};
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Stream tracking, updated only by step()
    bit          frame_active = 1'b0;
    int          n_beats = 0;
    int          n_reads = 0;
    bit          stalled = 1'b0;
    logic [81:0] prev_out = '0;

    // Observe one cycle at the falling edge, then move to just after the
    // next rising edge where the caller may change inputs.
    task automatic step();
        @(negedge clk);
        if (rst_200M) begin
            frame_active = 1'b0;
            n_beats      = 0;
            n_reads      = 0;
            stalled      = 1'b0;
        end else begin
            if (!frame_active) begin
                check("idle_quiet", {m_valid, ce0, busy}, 3'b000);
            end else begin
                if (stalled) begin
                    check("stall_hold", {m_valid, m_user, m_last, m_data}, {1'b1, prev_out});
                end
                if (ce0) begin
                    check("rd_addr", addr_q, n_reads);
                    check("rd_credit", ((n_reads + 1 - n_beats / BPL) <= 2), 1'b1);
                    n_reads++;
                end
                if (m_valid && m_ready) begin
                    check("beat", {m_user, m_last, m_data}, exp_beat(n_beats));
                    n_beats++;
                    if (n_beats == TOTAL) begin
                        check("reads_per_frame", n_reads, LINES);
                        frame_active = 1'b0;
                    end
                end
                stalled  = m_valid && !m_ready;
                prev_out = {m_user, m_last, m_data};
            end
            if (save_done && !busy) begin
                frame_active = 1'b1;
                n_beats      = 0;
                n_reads      = 0;
                stalled      = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Step until beat `target` is presented; rnd selects 30% random ready.
    task automatic wait_beat(input int target, input bit rnd, input int budget, input string name);
        int c;
        c = 0;
        while (!(n_beats == target && m_valid) && c < budget) begin
            if (rnd) m_ready = ($urandom_range(0, 99) < 30);
            step();
            c++;
        end
        check(name, (n_beats == target && m_valid), 1'b1);
    endtask

    typedef struct {
        int         line;
        int         beat;
        logic [7:0] in_val;
        logic [7:0] exp_pix;
    } corner_t;

    initial begin
        corner_t corners[6];
        int      cyc;

        corners[0] = '{0, 0, 8'd0,   8'd255};
        corners[1] = '{1, 2, 8'd1,   8'd254};
        corners[2] = '{2, 4, 8'd254, 8'd1};
        corners[3] = '{3, 1, 8'd255, 8'd0};
        corners[4] = '{4, 3, 8'd0,   8'd255};
        corners[5] = '{7, 0, 8'd255, 8'd0};

        rst_200M  = 1'b1;
        save_done = 1'b0;
        m_ready   = 1'b0;
        repeat (3) step();
        rst_200M = 1'b0;
        check("reset_state", {addr_q, ce0, m_data, m_valid, m_user, m_last, busy, overrun}, '0);
        step();

        // Pixel-map corners, all lanes, then reset in the middle of the frame
        for (int i = 0; i < 4; i++) corner_word[8*(corners[i].line % 4) +: 8] = corners[i].in_val;
        mem_mode  = 1;
        m_ready   = 1'b1;
        save_done = 1'b1;
        step();
        save_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_beat(corners[i].line * BPL + corners[i].beat, 1'b0, 200, "corner_reach");
            check("corner_px", m_data, {10{corners[i].exp_pix}});
        end
        wait_beat(12345, 1'b0, 20000, "reach_12345");
        rst_200M = 1'b1;
        step();
        rst_200M = 1'b0;
        check("rst_outputs", {addr_q, ce0, m_data, m_valid, m_user, m_last, busy, overrun}, '0);
        mem_mode = 0;
        repeat (10) step();

        // Full frame with ready held high
        save_done = 1'b1;
        step();
        save_done = 1'b0;
        check("start_c1", {busy, ce0, addr_q}, {1'b1, 1'b1, 13'd0});
        step();
        step();
        check("no_early_valid", m_valid, 1'b0);
        step();
        check("first_c4", {m_valid, m_user}, 2'b11);
        check("first_px", m_data[15:0], {8'd254, 8'd255});
        cyc = 0;
        while (frame_active && cyc < 30000) begin
            step();
            cyc++;
        end
        check("frame_cycles", cyc, TOTAL);
        check("busy_drop", busy, 1'b0);
        step();
        step();

        // Stall from start, random ready, overrun, then restart
        m_ready   = 1'b0;
        save_done = 1'b1;
        step();
        save_done = 1'b0;
        repeat (99) step();
        check("stall_reads", n_reads, 2);
        wait_beat(1000, 1'b1, 20000, "reach_1000");
        save_done = 1'b1;
        step();
        save_done = 1'b0;
        check("overrun_set", {overrun, busy}, 2'b11);
        wait_beat(2500, 1'b1, 20000, "reach_2500");
        m_ready = 1'b1;
        cyc = 0;
        while (frame_active && cyc < 40000) begin
            step();
            cyc++;
        end
        check("frame_b_beats", n_beats, TOTAL);
        check("busy_drop_b", {busy, overrun}, 2'b01);
        step();
        save_done = 1'b1;
        step();
        save_done = 1'b0;
        check("restart", {busy, ce0, addr_q}, {1'b1, 1'b1, 13'd0});
        wait_beat(20, 1'b0, 200, "restart_beats");
        check("overrun_sticky", overrun, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
